// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: default bus widths, reset vector and the
// fetch-entry layout (instruction word plus the address it came from).
package cpu_pkg;

   localparam int DEF_ADDR_W = 8;
   localparam int DEF_DATA_W = 16;

   localparam logic [DEF_ADDR_W-1:0] RESET_VECTOR = '0;

   typedef struct packed {
      logic [DEF_DATA_W-1:0] data;
      logic [DEF_ADDR_W-1:0] addr;
   } fetch_entry_t;

endpackage

// File: rtl/instr_prefetch_if.sv
// Fetch-side bundle: I_MEM read port, CPU instruction handshake and redirect.
interface instr_prefetch_if
   import cpu_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) ();

   logic [ADDR_W-1:0] mem_addr;
   logic              mem_oe;
   logic [DATA_W-1:0] mem_data;
   logic              ins_valid;
   logic [DATA_W-1:0] ins_data;
   logic [ADDR_W-1:0] ins_addr;
   logic              ins_ready;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_addr;

   modport master (
      output mem_addr, mem_oe, ins_valid, ins_data, ins_addr,
      input  mem_data, ins_ready, redirect, redirect_addr
   );

   modport slave (
      input  mem_addr, mem_oe, ins_valid, ins_data, ins_addr,
      output mem_data, ins_ready, redirect, redirect_addr
   );

endinterface

// File: rtl/prefetch_fifo.sv
// Synchronous FIFO with flush and a registered head entry; the head holds its
// last value whenever the FIFO is empty.
module prefetch_fifo
   import cpu_pkg::*;
#(
   parameter int WIDTH = DEF_DATA_W + DEF_ADDR_W,
   parameter int DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             head_valid,
   output logic [WIDTH-1:0] head_data,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem_reg [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
   logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic [WIDTH-1:0] head_reg, head_next;
   logic             head_valid_reg, head_valid_next;
   logic             do_push, do_pop;

   assign do_pop  = pop & head_valid_reg & ~flush;
   assign do_push = push & ~flush & ((count_reg != CNT_W'(DEPTH)) | do_pop);

   always_comb begin
      wr_ptr_next     = wr_ptr_reg + PTR_W'(do_push);
      rd_ptr_next     = rd_ptr_reg + PTR_W'(do_pop);
      count_next      = count_reg;
      head_next       = head_reg;
      head_valid_next = 1'b0;
      case ({do_push, do_pop})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
      if (flush) begin
         wr_ptr_next = '0;
         rd_ptr_next = '0;
         count_next  = '0;
      end else if (count_next != '0) begin
         head_valid_next = 1'b1;
         // New head lands in the slot being written this edge: bypass the array.
         if (do_push && (rd_ptr_next == wr_ptr_reg))
            head_next = push_data;
         else
            head_next = mem_reg[rd_ptr_next];
      end
   end

   always_ff @(posedge clk) begin
      if (do_push)
         mem_reg[wr_ptr_reg] <= push_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         count_reg      <= '0;
         head_reg       <= '0;
         head_valid_reg <= 1'b0;
      end else begin
         wr_ptr_reg     <= wr_ptr_next;
         rd_ptr_reg     <= rd_ptr_next;
         count_reg      <= count_next;
         head_reg       <= head_next;
         head_valid_reg <= head_valid_next;
      end
   end

   assign head_valid = head_valid_reg;
   assign head_data  = head_reg;
   assign count      = count_reg;

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetcher: issues sequential I_MEM reads ahead of the CPU and
// buffers returned words; a redirect flushes everything and restarts fetching.
module instr_prefetch
   import cpu_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              reset,
   instr_prefetch_if.master  bus
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [ADDR_W-1:0]        fpc_reg;
   logic [ADDR_W-1:0]        ret_addr_reg;
   logic                     ret_pend_reg;
   logic [CNT_W-1:0]         count;
   logic [CNT_W:0]           inflight;
   logic                     issue;
   logic                     head_valid;
   logic [DATA_W+ADDR_W-1:0] head_data;

   // Reserve a slot for the outstanding return so a push never meets a full FIFO.
   assign inflight = {1'b0, count} + (CNT_W + 1)'(ret_pend_reg);
   assign issue    = reset & ~bus.redirect & (inflight < (CNT_W + 1)'(DEPTH));

   assign bus.mem_oe   = issue;
   assign bus.mem_addr = fpc_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fpc_reg      <= ADDR_W'(RESET_VECTOR);
         ret_addr_reg <= '0;
         ret_pend_reg <= 1'b0;
      end else if (bus.redirect) begin
         fpc_reg      <= bus.redirect_addr;
         ret_pend_reg <= 1'b0;
      end else begin
         ret_pend_reg <= issue;
         if (issue) begin
            fpc_reg      <= fpc_reg + 1'b1;
            ret_addr_reg <= fpc_reg;
         end
      end
   end

   prefetch_fifo #(
      .WIDTH (DATA_W + ADDR_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .flush      (bus.redirect),
      .push       (ret_pend_reg),
      .push_data  ({bus.mem_data, ret_addr_reg}),
      .pop        (bus.ins_ready),
      .head_valid (head_valid),
      .head_data  (head_data),
      .count      (count)
   );

   assign bus.ins_valid = head_valid;
   assign bus.ins_data  = head_data[ADDR_W +: DATA_W];
   assign bus.ins_addr  = head_data[ADDR_W-1:0];

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed bench for instr_prefetch; I_MEM[k] = 0x100 + k, one-cycle read latency.
module tb_instr_prefetch;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 16;
   localparam int DEPTH  = 4;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   instr_prefetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   instr_prefetch #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.mem_oe)
         bus.mem_data <= 16'h0100 + {8'h00, bus.mem_addr};
   end

   int n_cmp = 0;
   int n_bad = 0;
   logic [ADDR_W-1:0] exp_addr;
   logic [ADDR_W-1:0] exp_issue;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Reset held across one rising edge; returns at the cycle-0 sample point.
   task automatic do_reset();
      bus.ins_ready     = 1'b0;
      bus.redirect      = 1'b0;
      bus.redirect_addr = '0;
      reset = 1'b0;
      #1;
      check("rst_oe", 32'(bus.mem_oe), 32'd0);
      check("rst_valid", 32'(bus.ins_valid), 32'd0);
      tick();
      reset = 1'b1;
      #1;
   endtask

   task automatic pop_check(input string tag);
      if (bus.ins_valid && bus.ins_ready) begin
         $display("%s pop addr=0x%02h data=0x%04h", tag, bus.ins_addr, bus.ins_data);
         check({tag, "_addr"}, 32'(bus.ins_addr), 32'(exp_addr));
         check({tag, "_data"}, 32'(bus.ins_data), 32'h100 + 32'(exp_addr));
         exp_addr = exp_addr + 1'b1;
      end
   endtask

   initial begin
      bus.ins_ready     = 1'b0;
      bus.redirect      = 1'b0;
      bus.redirect_addr = '0;
      #2;
      check("reset_oe", 32'(bus.mem_oe), 32'd0);
      check("reset_maddr", 32'(bus.mem_addr), 32'd0);
      check("reset_valid", 32'(bus.ins_valid), 32'd0);
      check("reset_idata", 32'(bus.ins_data), 32'd0);
      check("reset_iaddr", 32'(bus.ins_addr), 32'd0);

      // Streaming with ready high: one issue and one delivery per cycle.
      do_reset();
      bus.ins_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         check("t1_oe", 32'(bus.mem_oe), 32'd1);
         check("t1_maddr", 32'(bus.mem_addr), 32'(c));
         check("t1_valid", 32'(bus.ins_valid), 32'(c >= 2));
         if (c >= 2) begin
            check("t1_iaddr", 32'(bus.ins_addr), 32'(c - 2));
            check("t1_idata", 32'(bus.ins_data), 32'h100 + 32'(c - 2));
         end
         tick();
      end

      // Back-pressure: exactly DEPTH reads, then resume without gap or duplicate.
      do_reset();
      for (int c = 0; c < 8; c++) begin
         check("t2_oe", 32'(bus.mem_oe), 32'(c < 4));
         check("t2_maddr", 32'(bus.mem_addr), 32'((c < 4) ? c : 4));
         check("t2_valid", 32'(bus.ins_valid), 32'(c >= 2));
         tick();
      end
      bus.ins_ready = 1'b1;
      exp_addr  = 8'h00;
      exp_issue = 8'h04;
      for (int c = 8; c < 16; c++) begin
         check("t2_valid_run", 32'(bus.ins_valid), 32'd1);
         if (bus.mem_oe) begin
            check("t2_issue", 32'(bus.mem_addr), 32'(exp_issue));
            exp_issue = exp_issue + 1'b1;
         end
         pop_check("t2");
         tick();
      end
      check("t2_pops", 32'(exp_addr), 32'd8);

      // Redirect with 3 entries buffered and a read outstanding.
      do_reset();
      for (int c = 0; c < 4; c++) tick();
      check("t3_pre_valid", 32'(bus.ins_valid), 32'd1);
      bus.redirect      = 1'b1;
      bus.redirect_addr = 8'h40;
      #1;
      check("t3_redir_oe", 32'(bus.mem_oe), 32'd0);
      tick();
      bus.redirect = 1'b0;
      #1;
      check("t3_r1_valid", 32'(bus.ins_valid), 32'd0);
      check("t3_r1_oe", 32'(bus.mem_oe), 32'd1);
      check("t3_r1_maddr", 32'(bus.mem_addr), 32'h40);
      bus.ins_ready = 1'b1;
      tick();
      check("t3_r2_valid", 32'(bus.ins_valid), 32'd0);
      tick();
      check("t3_r3_valid", 32'(bus.ins_valid), 32'd1);
      exp_addr = 8'h40;
      for (int c = 0; c < 6; c++) begin
         pop_check("t3");
         tick();
      end
      check("t3_pops", 32'(exp_addr), 32'h46);

      // Redirect near the top of the address space: fetch wraps to 0.
      bus.redirect      = 1'b1;
      bus.redirect_addr = 8'hFE;
      tick();
      bus.redirect = 1'b0;
      check("t4_r1_valid", 32'(bus.ins_valid), 32'd0);
      tick();
      check("t4_r2_valid", 32'(bus.ins_valid), 32'd0);
      tick();
      exp_addr = 8'hFE;
      for (int c = 0; c < 4; c++) begin
         check("t4_valid", 32'(bus.ins_valid), 32'd1);
         pop_check("t4");
         tick();
      end
      check("t4_wrap", 32'(exp_addr), 32'h02);

      // Redirect coinciding with pop and return, then back-to-back redirects.
      check("t5_pre_valid", 32'(bus.ins_valid), 32'd1);
      bus.redirect      = 1'b1;
      bus.redirect_addr = 8'h80;
      #1;
      check("t5_redir_oe", 32'(bus.mem_oe), 32'd0);
      tick();
      check("t5_flush_valid", 32'(bus.ins_valid), 32'd0);
      bus.redirect_addr = 8'h90;
      #1;
      check("t5_b2b_oe", 32'(bus.mem_oe), 32'd0);
      tick();
      check("t5_b2b_valid", 32'(bus.ins_valid), 32'd0);
      bus.redirect_addr = 8'hA0;
      tick();
      bus.redirect = 1'b0;
      #1;
      check("t5_last_oe", 32'(bus.mem_oe), 32'd1);
      check("t5_last_maddr", 32'(bus.mem_addr), 32'hA0);
      check("t5_last_valid", 32'(bus.ins_valid), 32'd0);
      tick();
      check("t5_r4_valid", 32'(bus.ins_valid), 32'd0);
      tick();
      exp_addr = 8'hA0;
      for (int c = 0; c < 4; c++) begin
         check("t5_valid", 32'(bus.ins_valid), 32'd1);
         pop_check("t5");
         tick();
      end
      check("t5_pops", 32'(exp_addr), 32'hA4);

      // Mid-stream reset with a full FIFO, then random ready against the model.
      do_reset();
      for (int c = 0; c < 8; c++) tick();
      check("t6_full_oe", 32'(bus.mem_oe), 32'd0);
      check("t6_full_maddr", 32'(bus.mem_addr), 32'h04);
      reset = 1'b0;
      #1;
      check("t6_rst_oe", 32'(bus.mem_oe), 32'd0);
      check("t6_rst_maddr", 32'(bus.mem_addr), 32'd0);
      check("t6_rst_valid", 32'(bus.ins_valid), 32'd0);
      check("t6_rst_idata", 32'(bus.ins_data), 32'd0);
      check("t6_rst_iaddr", 32'(bus.ins_addr), 32'd0);
      tick();
      check("t6_rst_hold_oe", 32'(bus.mem_oe), 32'd0);
      reset = 1'b1;
      #1;
      check("t6_rel_oe", 32'(bus.mem_oe), 32'd1);
      check("t6_rel_maddr", 32'(bus.mem_addr), 32'd0);
      check("t6_rel_valid", 32'(bus.ins_valid), 32'd0);
      exp_addr = 8'h00;
      for (int c = 0; c < 80; c++) begin
         bus.ins_ready = 1'($urandom_range(0, 1));
         pop_check("t6");
         tick();
      end
      check("t6_progress", 32'(exp_addr > 8'd20), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
